// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, one result bit per cycle: y = floor(sqrt(x)).
// Optional ISQRT_SEQ_ROUND_EN rounds the result to nearest, saturating at all-ones.
module isqrt_seq #(
  parameter int unsigned N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_vld,
  input  logic [N-1:0]     x,
  output logic             x_rdy,
  output logic             y_vld,
  output logic [N/2-1:0]   y
);

  localparam int unsigned HW = N / 2;
  localparam int unsigned RW = HW + 2;
  localparam int unsigned CW = (HW > 1) ? $clog2(HW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    rad_q, rad_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [HW-1:0]   root_q, root_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            x_rdy_q, x_rdy_d;
  logic            y_vld_q, y_vld_d;
  logic [HW-1:0]   y_q, y_d;

  logic [RW-1:0]   rem_sh, trial, rem_nx;
  logic [HW-1:0]   root_nx, y_fin;
  logic            take;

  // One restoring digit step; the remainder width bounds the partial remainder without loss.
  always_comb begin
    rem_sh  = (rem_q << 2) | RW'(rad_q[N-1 -: 2]);
    trial   = (RW'(root_q) << 2) | RW'(1);
    take    = (rem_sh >= trial);
    rem_nx  = take ? (rem_sh - trial) : rem_sh;
    root_nx = (root_q << 1) | HW'(take);
  end

`ifdef ISQRT_SEQ_ROUND_EN
  // sqrt(x) >= root + 0.5 exactly when the final remainder exceeds root.
  always_comb begin
    y_fin = root_nx;
    if ((rem_nx > RW'(root_nx)) && (root_nx != '1)) begin
      y_fin = root_nx + HW'(1);
    end
  end
`else
  assign y_fin = root_nx;
`endif

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    x_rdy_d = x_rdy_q;
    y_vld_d = 1'b0;
    y_d     = y_q;
    case (state_q)
      IDLE, DONE: begin
        if (x_vld) begin
          state_d = CALC;
          rad_d   = x;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(HW - 1);
          x_rdy_d = 1'b0;
        end else begin
          state_d = IDLE;
          x_rdy_d = 1'b1;
        end
      end
      CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = rem_nx;
        root_d = root_nx;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          y_d     = y_fin;
          y_vld_d = 1'b1;
          x_rdy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        x_rdy_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      x_rdy_q <= 1'b1;
      y_vld_q <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      x_rdy_q <= x_rdy_d;
      y_vld_q <= y_vld_d;
      y_q     <= y_d;
    end
  end

  assign x_rdy = x_rdy_q;
  assign y_vld = y_vld_q;
  assign y     = y_q;

endmodule

// File: doc/isqrt_seq.md
# isqrt_seq

Sequential, area-lean integer square root: one argument at a time, one result bit per cycle, `y = floor(sqrt(x))`. It sits directly downstream of the sqrt-formula FSMs (formula 1 impl 1/2, formula 2) and is the unit they drive with `x_vld`/`x` and wait on via `y_vld`/`y`. It is a drop-in alternative to the pipelined isqrt, trading throughput for roughly one adder's worth of logic. It adds `x_rdy` so callers can see when it is busy.

## Interface
- `n`, default 32: argument width; must be even and ≥ 4; result width is `n/2`.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset: asynchronous, active-high.
- `x_vld`  input  1  argument valid; sampled only when `x_rdy` is 1.
- `x`  input  n  unsigned argument.
- `x_rdy`  output  1  block can accept an argument this cycle.
- `y_vld`  output  1  one-cycle pulse; `y` is valid while it is high.
- `y`  output  n/2  unsigned result; holds its last value until the next result.

## Operation
- **Reset values:** state IDLE, `x_rdy=1`, `y_vld=0`, `y=0`, internal radicand/remainder/root/counter all 0.
- **States:**
  - IDLE: `x_rdy=1`. Moves to CALC when `x_vld=1`.
  - CALC: `x_rdy=0`. Runs n/2 iterations, then moves to DONE.
  - DONE: `x_rdy=1` and `y_vld=1` for exactly one cycle. Moves to CALC if `x_vld=1`, otherwise to IDLE.
- **Acceptance:** on the accepting edge, capture `x` into the radicand shift register, clear remainder and root, and load the counter with n/2−1.
- **Iteration (restoring, digit-by-digit):** each CALC cycle does:
  - `rem' = (rem << 2) | top two bits of radicand`; shift the radicand left by 2.
  - `trial = (root << 2) | 1`.
  - If `rem' ≥ trial`: `rem = rem' − trial` and `root = (root << 1) | 1`.
  - Otherwise: `rem = rem'` and `root = root << 1`.
- **Widths:** remainder is n/2+2 bits; `trial` is computed at the same width; no truncation is permitted.
- **Exit:** when the counter reaches 0 in CALC, register the final root into `y` and go to DONE.
- **Busy arguments:** `x_vld` while `x_rdy=0` is ignored. There is no queue and no error flag; callers must respect `x_rdy`.
- **Stable inputs:** `x` need not be held after the accepting edge.
- **Output hold:** `y` holds after `y_vld` falls; `y_vld` never asserts for two consecutive cycles.

## Timing
- **Latency:** argument accepted at edge N → CALC iterations at edges N+1 … N+n/2 → `y`/`y_vld` visible in the cycle after edge N+n/2. For n=32 that is 16 cycles after acceptance.
- **Throughput:** back-to-back accept in DONE gives one result every n/2+1 cycles (17 for n=32). Going through IDLE costs one more cycle.
- **Reset:** `rst` asserted mid-CALC or in DONE immediately (asynchronously) forces the reset values. No `y_vld` is produced for the aborted argument. The first acceptance is allowed on the first rising edge after `rst` deasserts.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.

## Configuration
- `ISQRT_SEQ_ROUND_EN`:
  - **Defined:** the result is rounded to nearest, i.e. `y = root + 1` when the final remainder `> root`, otherwise `root`. The result saturates at 2^(n/2)−1. Latency is unchanged; the correction is folded into the CALC→DONE register write.
  - **Undefined:** the result is pure floor, as required by the formula FSM reference models.

## Test plan
- **Basic values (floor build):** x=0 → y=0; x=1 → 1; x=15 → 3; x=16 → 4; x=1000000 → 1000; x=0xFFFFFFFF → 65535. Each `y_vld` pulse occurs exactly 16 cycles after acceptance and is one cycle wide.
- **Rounding (`ISQRT_SEQ_ROUND_EN` defined):** x=15 → 4; x=12 → 3; x=0xFFFFFFFF → 65535 (saturated); x=16 → 4.
- **Back-to-back:** hold `x_vld=1` with x=81, then x=144 presented in the DONE cycle. Expected: y=9 and y=12, with `y_vld` pulses 17 cycles apart.
- **Busy-ignore:** pulse `x_vld` with x=49 while CALC runs on x=25. Expected: exactly one result, y=5, and `x_rdy=0` throughout CALC.
- **Reset mid-operation:** assert `rst` at iteration 7 of x=400. Expected: `y_vld` stays 0, `y=0`, and `x_rdy=1` immediately. A following x=400 yields 20 with the normal latency.
- **Random compare:** 10,000 random x with random `x_vld` gaps, checked against `$floor($sqrt(x))` (or its rounded form under the macro). Also check that `y` is held stable between `y_vld` pulses.
